// File: rtl/add_sub_serial.sv
// add_sub_serial: LSB-first bit-serial adder/subtractor with a key-locked result path.
// A wrong key flips result bits and carry-out deterministically; the arithmetic itself is untouched.
module add_sub_serial #(
    parameter int WIDTH = 8,
    parameter int KEY_W = 8,
    parameter logic [KEY_W-1:0] KEY = 8'hA5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [KEY_W-1:0] key,
    output logic [WIDTH-1:0] out,
    output logic             cout,
    output logic             ovf,
    output logic             busy,
    output logic             done
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, out_q, out_d;
    logic [KEY_W-1:0] kdiff_q, kdiff_d;
    logic [CW-1:0]    count_q, count_d;
    logic             carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d;
    logic             s, c, last, start;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = (state_q == IDLE) ? (en ? ADD : IDLE) :
                  (state_q == ADD)  ? (last ? DONE : ADD) : IDLE;
    end

    always_comb begin
        busy = (state_q == ADD);
        done = (state_q == DONE);
    end

    // kdiff rotates each ADD cycle so bit 0 always holds kdiff[count mod KEY_W]
    always_comb begin
        start   = (state_q == IDLE) && en;
        last    = (state_q == ADD) && (count_q == CW'(WIDTH - 1));
        s       = a_q[0] ^ b_q[0] ^ carry_q;
        c       = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);
        a_d     = a_q;
        b_d     = b_q;
        out_d   = out_q;
        kdiff_d = kdiff_q;
        count_d = count_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        if (start) begin
            a_d     = a;
            b_d     = sub ? ~b : b;
            carry_d = sub;
            count_d = '0;
            out_d   = '0;
            kdiff_d = key ^ KEY;
        end else if (state_q == ADD) begin
            out_d   = {s ^ kdiff_q[0], out_q[WIDTH-1:1]};
            carry_d = c;
            a_d     = a_q >> 1;
            b_d     = b_q >> 1;
            kdiff_d = (kdiff_q >> 1) | (kdiff_q << (KEY_W - 1));
            count_d = last ? count_q : count_q + 1'b1;
            if (last) begin
                cout_d = c ^ (|kdiff_q);
                ovf_d  = carry_q ^ c;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            out_q   <= '0;
            kdiff_q <= '0;
            count_q <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            out_q   <= out_d;
            kdiff_q <= kdiff_d;
            count_q <= count_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign out  = out_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;
endmodule

// File: tb/tb_add_sub_serial.sv
// tb_add_sub_serial: table vectors, random ops against an arithmetic model, and handshake/reset sequences
// for 8-bit and 16-bit instances.
module tb_add_sub_serial;
    logic        clk = 1'b0;
    logic        rst;
    logic        en8, sub8, cout8, ovf8, busy8, done8;
    logic [7:0]  a8, b8, key8, out8;
    logic        en16, sub16, cout16, ovf16, busy16, done16;
    logic [15:0] a16, b16, out16;
    logic [7:0]  key16;

    int n_chk = 0;
    int n_fail = 0;

    add_sub_serial #(.WIDTH(8)) u8 (
        .clk(clk), .rst(rst), .en(en8), .sub(sub8), .a(a8), .b(b8), .key(key8),
        .out(out8), .cout(cout8), .ovf(ovf8), .busy(busy8), .done(done8)
    );

    add_sub_serial #(.WIDTH(16)) u16 (
        .clk(clk), .rst(rst), .en(en16), .sub(sub16), .a(a16), .b(b16), .key(key16),
        .out(out16), .cout(cout16), .ovf(ovf16), .busy(busy16), .done(done16)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    typedef struct {
        logic [7:0] a, b;
        bit         sub;
        logic [7:0] key;
        logic [7:0] eo;
        bit         ec, ev;
    } vec_t;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Exact sum/difference, unsigned carry/no-borrow and signed overflow, then the key corruption.
    function automatic void model(input int w, input logic [31:0] a, input logic [31:0] b, input bit s,
                                  input logic [7:0] k, output logic [31:0] o, output bit c, output bit v);
        logic [31:0] r;
        logic [7:0]  kd;
        bit          sa, sb, sr;
        r  = s ? a - b : a + b;
        c  = s ? (a >= b) : r[w];
        o  = r & ((32'd1 << w) - 1);
        sa = a[w-1];
        sb = b[w-1];
        sr = o[w-1];
        v  = s ? (sa != sb && sr != sa) : (sa == sb && sr != sa);
        kd = k ^ 8'hA5;
        for (int i = 0; i < w; i++) o[i] = o[i] ^ kd[i % 8];
        c = c ^ (|kd);
    endfunction

    // Starts one operation, optionally pokes en and scrambles operands mid-ADD, returns at the first IDLE cycle.
    task automatic op(input int w, input logic [15:0] ai, input logic [15:0] bi, input bit si,
                      input logic [7:0] ki, input bit mid,
                      output logic [31:0] o, output bit c, output bit v);
        int lat;
        @(negedge clk);
        if (w == 8) begin a8 = ai[7:0]; b8 = bi[7:0]; sub8 = si; key8 = ki; en8 = 1'b1; end
        else begin a16 = ai; b16 = bi; sub16 = si; key16 = ki; en16 = 1'b1; end
        @(negedge clk);
        en8 = 1'b0;
        en16 = 1'b0;
        lat = 0;
        check("busy_start", (w == 8) ? busy8 : busy16, 1);
        while (!((w == 8) ? done8 : done16) && lat < 64) begin
            if (mid && lat == 3) begin
                en8 = 1'b1;
                a8  = ~a8;
                b8  = b8 + 8'h37;
            end else begin
                en8 = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        check("done_lat", lat, w);
        o = (w == 8) ? {24'd0, out8} : {16'd0, out16};
        c = (w == 8) ? cout8 : cout16;
        v = (w == 8) ? ovf8 : ovf16;
        @(negedge clk);
        check("done_pulse", (w == 8) ? done8 : done16, 0);
        check("busy_end", (w == 8) ? busy8 : busy16, 0);
    endtask

    task automatic verify(input string n, input logic [31:0] o, input bit c, input bit v,
                          input logic [31:0] eo, input bit ec, input bit ev);
        check({n, "_out"}, o, eo);
        check({n, "_cout"}, c, ec);
        check({n, "_ovf"}, v, ev);
    endtask

    initial begin
        vec_t        tbl[4];
        logic [31:0] o, eo;
        bit          c, v, ec, ev;
        logic [15:0] ra, rb;
        logic [7:0]  rk;
        bit          rs;
        int          t[$];

        tbl[0] = '{8'h3C, 8'h5A, 1'b0, 8'hA5, 8'h96, 1'b0, 1'b1};
        tbl[1] = '{8'h10, 8'h20, 1'b1, 8'hA5, 8'hF0, 1'b0, 1'b0};
        tbl[2] = '{8'hFF, 8'h01, 1'b0, 8'hA5, 8'h00, 1'b1, 1'b0};
        tbl[3] = '{8'h3C, 8'h5A, 1'b0, 8'hA4, 8'h97, 1'b1, 1'b1};

        rst = 1'b1;
        {en8, sub8, a8, b8, key8} = '0;
        {en16, sub16, a16, b16, key16} = '0;
        repeat (2) @(negedge clk);
        verify("reset8", {24'd0, out8}, cout8, ovf8, 0, 0, 0);
        check("reset_busy", busy8, 0);
        check("reset_done", done8, 0);
        verify("reset16", {16'd0, out16}, cout16, ovf16, 0, 0, 0);
        rst = 1'b0;

        foreach (tbl[i]) begin
            op(8, {8'd0, tbl[i].a}, {8'd0, tbl[i].b}, tbl[i].sub, tbl[i].key, 1'b0, o, c, v);
            verify($sformatf("vec%0d", i), o, c, v, {24'd0, tbl[i].eo}, tbl[i].ec, tbl[i].ev);
        end

        op(16, 16'h8000, 16'h0001, 1'b1, 8'hA5, 1'b0, o, c, v);
        verify("w16_sub", o, c, v, 32'h7FFF, 1, 1);

        for (int i = 0; i < 24; i++) begin
            int w;
            w  = (i % 4 == 3) ? 16 : 8;
            ra = 16'($urandom);
            rb = 16'($urandom);
            if (w == 8) begin ra[15:8] = 8'd0; rb[15:8] = 8'd0; end
            rs = 1'($urandom);
            rk = ($urandom % 2) ? 8'hA5 : 8'($urandom);
            op(w, ra, rb, rs, rk, 1'b0, o, c, v);
            model(w, {16'd0, ra}, {16'd0, rb}, rs, rk, eo, ec, ev);
            verify($sformatf("rand%0d", i), o, c, v, eo, ec, ev);
        end

        // en dropped mid-ADD and operands changed after capture
        op(8, 16'h003C, 16'h005A, 1'b0, 8'hA5, 1'b1, o, c, v);
        verify("mid_en", o, c, v, 32'h96, 0, 1);
        repeat (2) @(negedge clk);
        check("dropped_en_busy", busy8, 0);

        // en held high: a new operation every WIDTH+2 cycles
        @(negedge clk);
        a8 = 8'h3C; b8 = 8'h5A; sub8 = 1'b0; key8 = 8'hA5; en8 = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done8) t.push_back(i);
        end
        en8 = 1'b0;
        check("cont_count", t.size(), 4);
        if (t.size() > 0) check("cont_first", t[0], 8);
        for (int k = 1; k < t.size(); k++) check("cont_period", t[k] - t[k-1], 10);
        check("cont_out", out8, 8'h96);
        repeat (2) @(negedge clk);

        // reset after 4 ADD cycles, with cout left at 1 by the previous op
        op(8, 16'h00FF, 16'h0001, 1'b0, 8'hA5, 1'b0, o, c, v);
        verify("pre_rst", o, c, v, 0, 1, 0);
        @(negedge clk);
        a8 = 8'h3C; b8 = 8'h5A; sub8 = 1'b0; key8 = 8'hA5; en8 = 1'b1;
        @(negedge clk);
        en8 = 1'b0;
        repeat (4) @(negedge clk);
        check("mid_busy", busy8, 1);
        rst = 1'b1;
        #1;
        verify("mid_rst", {24'd0, out8}, cout8, ovf8, 0, 0, 0);
        check("mid_rst_busy", busy8, 0);
        check("mid_rst_done", done8, 0);
        @(negedge clk);
        rst = 1'b0;
        op(8, 16'h0001, 16'h0001, 1'b0, 8'hA5, 1'b0, o, c, v);
        verify("post_rst", o, c, v, 32'h02, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
